// File: rtl/pipe_reg_pkg.sv
// Shared defaults and helpers for the pipe_reg_vr valid/ready register pipeline.
package pipe_reg_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Bits needed to hold values 0..n-1; used to size the occupancy counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data slot of the pipeline; loads from upstream whenever it is empty or
// downstream can take its current word.
module pipe_stage
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign rdy   = ~valid_q | dn_ready;
    assign valid = valid_q;
    assign data  = data_q;

    // Flush wins over en so a held pipe can still be cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (en && rdy) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_vr.sv
// WIDTH-bit, DEPTH-stage stallable register pipeline with bubble collapsing.
// Define PIPE_REG_VR_OCC_EN to add the registered occupancy output.
module pipe_reg_vr
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter int unsigned      DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_VR_OCC_EN
    ,
    output logic [clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [DEPTH-1:0] dn_r;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];

    // Stage i's ready depends on stage i+1, forming the output-to-input ready chain.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_v[i] = in_valid;
            assign up_d[i] = in_data;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end
        if (i == DEPTH - 1) begin : g_tail
            assign dn_r[i] = out_ready;
        end else begin : g_mid
            assign dn_r[i] = rdy[i+1];
        end

        pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .flush    (flush),
            .up_valid (up_v[i]),
            .up_data  (up_d[i]),
            .dn_ready (dn_r[i]),
            .valid    (v[i]),
            .data     (d[i]),
            .rdy      (rdy[i])
        );
    end

    assign in_ready  = en & ~flush & ~rst & rdy[0];
    assign out_valid = en & v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef PIPE_REG_VR_OCC_EN
    localparam int unsigned OccW = clog2(DEPTH + 1);

    logic [OccW-1:0] occ_q;
    logic [OccW-1:0] occ_d;
    logic            in_xfer;
    logic            out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign occupancy = occ_q;

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OccW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (en) begin
            occ_q <= occ_d;
        end
    end
`endif

endmodule
